// File: rtl/shifter_pipe.sv
// ---------------------------------------------------------------------------
// shifter_pipe
//
// Pipelined barrel shifter for the ALU execute path. Supported operations are
// SLL, SRL, SRA, ROR and ROL on a WIDTH-bit operand. Stage k handles bit k of
// the shift amount, so there are SHW = $clog2(WIDTH) registered stages and
// the latency is SHW cycles.
//
// Flow control is a valid/ready pair on each side with global backpressure.
// When the output beat is presented but not taken, every stage holds.
// Otherwise the whole pipeline advances by one, and bubbles travel with it.
//
// Optional feature: define SHIFTER_PIPE_FLAGS_EN to add out_zero and
// out_carry. Both flags are pipelined alongside the data. Without the macro
// the flag ports and flag registers are absent, and the data path and timing
// are unchanged.
// ---------------------------------------------------------------------------
module shifter_pipe #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_amt,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
`ifdef SHIFTER_PIPE_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    // Operation encoding. The codes 3'b101..3'b111 are reserved. A reserved
    // op passes the operand through unchanged and ignores the amount.
    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROR = 3'b011,
        OP_ROL = 3'b100
    } op_e;

    // Everything one stage register carries. The full amount travels down
    // the pipe, and stage k only looks at amt[k]. The carry is the last bit
    // that crossed the word boundary so far. The zero flag is recomputed at
    // every stage from that stage's value, so the copy in the last register
    // always matches out_result.
    typedef struct packed {
        logic             valid;
        logic [2:0]       op;
        logic [WIDTH-1:0] val;
        logic [SHW-1:0]   amt;
`ifdef SHIFTER_PIPE_FLAGS_EN
        logic             carry;
        logic             zero;
`endif
    } stage_t;

    // chain[0] is the incoming beat. chain[k+1] is the register after
    // stage k, and chain[SHW] is the output register.
    stage_t chain [SHW+1];
    stage_t stage_in;
    logic   stall;

    // A presented but unaccepted result freezes the whole pipe. in_ready
    // depends only on the output side, never on in_valid, so no
    // combinational path runs from in_valid to in_ready.
    assign stall    = chain[SHW].valid & ~out_ready;
    assign in_ready = ~stall;

    // Build the stage-0 input from the ports. When nothing is accepted,
    // valid is 0 and a bubble enters the pipe.
    always_comb begin
        // NOTE: every field gets a value before any conditional logic, so
        // this combinational block cannot infer a latch.
        stage_in       = '0;
        stage_in.valid = in_valid & in_ready;
        stage_in.op    = in_op;
        stage_in.val   = in_a;
        stage_in.amt   = in_amt;
    end

    assign chain[0] = stage_in;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        // Distance handled by this stage. Because k < SHW, SH is at most
        // WIDTH/2, so the rotate counterpart (WIDTH - SH) is never 0.
        localparam int SH = 1 << k;

        stage_t stage_d;
        stage_t stage_q;
        stage_t src;

        assign src = chain[k];

        // Shift or rotate by SH when amt[k] is set, otherwise pass through.
        always_comb begin
            stage_d = src;
            if (src.amt[k]) begin
                case (src.op)
                    OP_SLL: begin
                        stage_d.val   = src.val << SH;
`ifdef SHIFTER_PIPE_FLAGS_EN
                        stage_d.carry = src.val[WIDTH-SH];
`endif
                    end
                    OP_SRL: begin
                        stage_d.val   = src.val >> SH;
`ifdef SHIFTER_PIPE_FLAGS_EN
                        stage_d.carry = src.val[SH-1];
`endif
                    end
                    OP_SRA: begin
                        // Fill with the sign bit of the value entering this
                        // stage. That bit always equals in_a[MSB].
                        stage_d.val   = $signed(src.val) >>> SH;
`ifdef SHIFTER_PIPE_FLAGS_EN
                        stage_d.carry = src.val[SH-1];
`endif
                    end
                    OP_ROR: begin
                        stage_d.val   = (src.val >> SH) | (src.val << (WIDTH - SH));
`ifdef SHIFTER_PIPE_FLAGS_EN
                        // This bit lands in the new MSB.
                        stage_d.carry = src.val[SH-1];
`endif
                    end
                    OP_ROL: begin
                        stage_d.val   = (src.val << SH) | (src.val >> (WIDTH - SH));
`ifdef SHIFTER_PIPE_FLAGS_EN
                        // This bit lands in the new LSB.
                        stage_d.carry = src.val[WIDTH-SH];
`endif
                    end
                    default: begin
                        // Reserved op: the value and the carry pass unchanged.
                    end
                endcase
            end
`ifdef SHIFTER_PIPE_FLAGS_EN
            stage_d.zero = (stage_d.val == '0);
`endif
        end

        // Pipeline register for stage k. It advances when the output is not
        // stalled and holds otherwise.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // NOTE: data fields are cleared along with valid, so the
                // output reads 0 after reset instead of stale values. A reset
                // also drops any beats that were in flight.
                stage_q <= '0;
            end else if (!stall) begin
                // NOTE: non-blocking assignment, so every stage samples its
                // predecessor's value from before this clock edge.
                stage_q <= stage_d;
            end
        end

        assign chain[k+1] = stage_q;
    end : g_stage

    assign out_valid  = chain[SHW].valid;
    assign out_result = chain[SHW].val;
`ifdef SHIFTER_PIPE_FLAGS_EN
    assign out_zero   = chain[SHW].zero;
    assign out_carry  = chain[SHW].carry;
`endif

endmodule : shifter_pipe

// File: tb/tb_shifter_pipe.sv
// ---------------------------------------------------------------------------
// tb_shifter_pipe
//
// Directed bench for shifter_pipe with WIDTH=16. The stimulus pushes the
// hand-computed expected response into a queue when a beat is accepted. A
// monitor pops and compares whenever an output beat is handed over. Define
// SHIFTER_PIPE_FLAGS_EN for both files to exercise the flag outputs.
// ---------------------------------------------------------------------------
module tb_shifter_pipe;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    localparam logic [2:0] SLL = 3'b000;
    localparam logic [2:0] SRL = 3'b001;
    localparam logic [2:0] SRA = 3'b010;
    localparam logic [2:0] ROR = 3'b011;
    localparam logic [2:0] ROL = 3'b100;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             carry;
        int               acc;
        bit               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [SHW-1:0]   in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
`ifdef SHIFTER_PIPE_FLAGS_EN
    logic             out_zero;
    logic             out_carry;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    shifter_pipe #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_amt     (in_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef SHIFTER_PIPE_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_carry  (out_carry)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Present one beat. The task is called at posedge+1. It returns at
    // posedge+1 after the beat has been accepted.
    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [SHW-1:0] amt, input logic [WIDTH-1:0] res,
                        input logic carry, input bit lat);
        exp_t e;
        int   n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_amt   = amt;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.res   = res;
            e.carry = carry;
            e.acc   = cyc + 1;
            e.lat   = lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until every expected beat has been seen, with a bounded budget.
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    // Monitor: pairs each output handshake with the oldest expectation and
    // checks the stall rules.
    initial begin : monitor
        exp_t             e;
        bit               held_v;
        logic [WIDTH-1:0] held_res;
        held_v   = 1'b0;
        held_res = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
                if (out_valid && out_ready) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 32'(out_result), 32'(e.res));
`ifdef SHIFTER_PIPE_FLAGS_EN
                        check("carry", 32'(out_carry), 32'(e.carry));
                        check("zero", 32'(out_zero), 32'(e.res == '0));
`endif
                        if (e.lat) check("latency", 32'(cyc - e.acc), 32'd3);
                    end
                end else if (out_valid) begin
                    if (held_v) check("held_result", 32'(out_result), 32'(held_res));
                    held_v   = 1'b1;
                    held_res = out_result;
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_amt    = '0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFTER_PIPE_FLAGS_EN
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Isolated beats, each checked for latency as well as value.
        send(SRA, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 1'b1); drain();
        send(SRA, 16'h4000, 4'd14, 16'h0001, 1'b0, 1'b1); drain();
        send(ROR, 16'h1234, 4'd4,  16'h4123, 1'b0, 1'b1); drain();
        send(ROL, 16'h8001, 4'd1,  16'h0003, 1'b1, 1'b1); drain();
        send(SLL, 16'h0001, 4'd15, 16'h8000, 1'b0, 1'b1); drain();
        send(SRL, 16'hFFFF, 4'd8,  16'h00FF, 1'b1, 1'b1); drain();
        send(ROL, 16'h1234, 4'd4,  16'h2341, 1'b1, 1'b1); drain();
        send(SRA, 16'hF000, 4'd4,  16'hFF00, 1'b0, 1'b1); drain();
        send(SRL, 16'h8421, 4'd3,  16'h1084, 1'b0, 1'b1); drain();
        send(SLL, 16'h8000, 4'd1,  16'h0000, 1'b1, 1'b1); drain();

        // Amount 0 and reserved op: the operand passes through, carry 0.
        send(SLL, 16'hABCD, 4'd0, 16'hABCD, 1'b0, 1'b0);
        send(SRL, 16'hABCD, 4'd0, 16'hABCD, 1'b0, 1'b0);
        send(SRA, 16'hABCD, 4'd0, 16'hABCD, 1'b0, 1'b0);
        send(ROR, 16'hABCD, 4'd0, 16'hABCD, 1'b0, 1'b0);
        send(ROL, 16'hABCD, 4'd0, 16'hABCD, 1'b0, 1'b0);
        send(3'b110, 16'h5A5A, 4'd7, 16'h5A5A, 1'b0, 1'b0);
        send(3'b111, 16'h0000, 4'd9, 16'h0000, 1'b0, 1'b0);
        drain();

        // Backpressure: 8 back-to-back beats, out_ready low for 3 cycles.
        fork
            begin
                send(SLL, 16'h0003, 4'd1,  16'h0006, 1'b0, 1'b0);
                send(SLL, 16'h0003, 4'd2,  16'h000C, 1'b0, 1'b0);
                send(SRL, 16'h00F0, 4'd4,  16'h000F, 1'b0, 1'b0);
                send(SRL, 16'h00F0, 4'd5,  16'h0007, 1'b1, 1'b0);
                send(SRA, 16'h8000, 4'd1,  16'hC000, 1'b0, 1'b0);
                send(ROR, 16'h000F, 4'd4,  16'hF000, 1'b1, 1'b0);
                send(ROL, 16'hF000, 4'd4,  16'h000F, 1'b1, 1'b0);
                send(SLL, 16'hFFFF, 4'd15, 16'h8000, 1'b1, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with 3 beats in flight: those beats must vanish.
        send(SLL, 16'h1111, 4'd1, 16'h2222, 1'b0, 1'b0);
        send(SLL, 16'h2222, 4'd1, 16'h4444, 1'b0, 1'b0);
        send(SLL, 16'h4444, 4'd1, 16'h8888, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_result", 32'(out_result), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("postrst_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(SLL, 16'h0001, 4'd3, 16'h0008, 1'b0, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shifter_pipe

// File: doc/shifter_pipe.md
# shifter_pipe

Pipelined, parametrised barrel shifter for the ALU execute path. It supports logical left, logical right, arithmetic right, rotate right and rotate left on a WIDTH-bit operand. The block resolves one shift-amount bit per pipeline stage and registers every stage. A valid/ready handshake on both sides gives full throughput with global backpressure.

## Interface
Parameters:
- WIDTH, 16: operand and result width in bits; power of two, at least 4.
- SHW, $clog2(WIDTH): shift-amount width and pipeline depth (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL; 101–111 reserved.
- in_a  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0 to WIDTH-1.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the beat.
- out_result  output  WIDTH  shifted or rotated value.
- out_zero, out_carry  output  1 each  present only with SHIFTER_PIPE_FLAGS_EN (see Configuration).

## Operation
- Stage k, for k = 0 to SHW-1, shifts or rotates by 2^k when the carried amt[k] is 1. Otherwise it passes the value through.
- The register after stage k holds the following: valid, op, the partial value, the remaining amount bits, and the carry when flags are enabled.
- SLL and SRL fill with 0.
- SRA fills with the sign bit of the value entering that stage. This is equal to in_a[MSB] at every stage.
- ROR and ROL are modulo WIDTH.
- in_amt = 0 gives out_result = in_a for every op.
- A reserved op gives out_result = in_a and the amount is ignored.
- Stall condition: stall = out_valid & ~out_ready.
  - in_ready = ~stall. This is combinational; it does not depend on in_valid.
  - While stall is high, every pipeline register, valid bits included, holds its value.
  - While stall is low, every stage advances by one.
  - A beat is accepted when in_valid & in_ready.
  - A stage that receives no beat loads valid = 0. Bubbles propagate and are not collapsed.
- There is no other state machine. The only state is the SHW-deep pipeline.

## Timing
- Latency is SHW cycles.
  - A beat accepted at rising edge t appears with out_valid = 1 after edge t+SHW-1 (SHW register stages), provided no stall occurs in between.
  - Each stall cycle adds 1 cycle of latency.
- Throughput is 1 beat per cycle with out_ready held at 1.
- Consecutive results appear in acceptance order; none are dropped or duplicated.
- out_result, out_zero and out_carry are stable while out_valid & ~out_ready.
- On reset, all valid bits and data registers clear to 0.
  - out_valid = 0, out_result = 0, out_zero = 0, out_carry = 0.
  - in_ready = 1 from the cycle after reset asserts.
- If rst asserts mid-operation, in-flight beats are discarded and no partial result is emitted.
- in_valid while rst is high is ignored.
- With simultaneous output and input handshakes in one cycle, both transfer and the pipeline advances.

## Configuration
- SHIFTER_PIPE_FLAGS_EN defined:
  - out_zero and out_carry ports exist and are pipelined alongside the data.
  - out_zero = (out_result == 0).
  - out_carry is the last bit shifted or rotated across the boundary:
    - SLL: in_a[WIDTH-amt].
    - SRL and SRA: in_a[amt-1].
    - ROR: out_result[WIDTH-1].
    - ROL: out_result[0].
    - Amount 0 or a reserved op: 0.
- SHIFTER_PIPE_FLAGS_EN undefined: the ports and the carry/zero registers are absent. Data path and timing are unchanged.

## Test plan
All cases use WIDTH=16, so SHW=4.
- SRA: 0x8000 by 15 → out_result 0xFFFF exactly 4 cycles after acceptance. SRA 0x4000 by 14 → 0x0001.
- Rotates: ROR 0x1234 by 4 → 0x4123. ROL 0x8001 by 1 → 0x0003, with out_carry 1 when flags are enabled.
- Shifts and edge cases:
  - SLL 0x0001 by 15 → 0x8000.
  - SRL 0xFFFF by 8 → 0x00FF.
  - Any op by 0 → unchanged.
  - Op 110 → in_a.
- Backpressure: stream 8 back-to-back beats with out_ready low for 3 cycles mid-stream. Required: all 8 results appear in order, none lost, in_ready = 0 exactly during the stall, and the held output is stable.
- Reset: assert rst with 3 beats in flight. Required: out_valid = 0 immediately and stays 0 after release until a new beat completes 4 cycles later.
- Flags (flags build only): SLL 0x8000 by 1 → out_result 0, out_zero 1, out_carry 1.
